uart_fifo_mmio: RTL

//  Memory-mapped full-duplex 8N1 UART with parametrised TX/RX FIFOs, runtime baud divisor and interrupt.

---
 rtl/uart_fifo_mmio_if.sv | 11 +
 rtl/uart_fifo_mmio.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_mmio_if.sv
// uart_fifo_mmio_if: CPU data-bus port of the memory-mapped UART
interface uart_fifo_mmio_if;
   logic [31:0] memAddress;
   logic [31:0] memWriteData;
   logic        memWrite;
   logic        memRead;
   logic [3:0]  byteMask;
   logic [31:0] memReadData;
   modport master (output memAddress, memWriteData, memWrite, memRead, byteMask, input memReadData);
   modport slave (input memAddress, memWriteData, memWrite, memRead, byteMask, output memReadData);
endinterface

// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped 8N1 UART with TX/RX FIFOs, runtime baud divisor and level interrupt
module uart_fifo_mmio #(
   parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FFE0,
   parameter int          TX_DEPTH        = 16,
   parameter int          RX_DEPTH        = 16,
   parameter logic [15:0] CLK_DIV_DEFAULT = 16'd5
) (
   input  logic           clk,
   input  logic           reset,
   uart_fifo_mmio_if.slave bus,
   output logic           uart_tx,
   input  logic           uart_rx,
   output logic           irq
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
   logic [31:0] off, wmask, status, ctrl_d, ctrl_q, rdata_d, rdata_q;
   logic [15:0] baud_q, div_q;
   logic [1:0]  sel;
   logic        hit, wr, rd, tick, irq_q;
   logic [2:0]  flags_q, flags_d, flags_clr;
   logic [7:0]     tx_mem_q [TX_DEPTH];
   logic [TAW-1:0] tx_wp_q, tx_rp_q;
   logic [TAW:0]   tx_cnt_q;
   logic           tx_full, tx_empty, tx_push_req, tx_push, tx_pop, tx_busy, tx_line_q;
   state_e         tx_st_q;
   logic [3:0]     tx_tk_q;
   logic [2:0]     tx_bit_q;
   logic [7:0]     tx_sh_q;
   logic [7:0]     rx_mem_q [RX_DEPTH];
   logic [RAW-1:0] rx_wp_q, rx_rp_q;
   logic [RAW:0]   rx_cnt_q;
   logic           rx_full, rx_empty, rx_push_req, rx_push, rx_pop, rx_stop, rx_s, rx_prev_q;
   logic [1:0]     rx_sync_q;
   state_e         rx_st_q;
   logic [3:0]     rx_tk_q;
   logic [2:0]     rx_bit_q;
   logic [7:0]     rx_sh_q;
   assign off   = bus.memAddress - BASE_ADDR;
   assign hit   = off < 32'd16;
   assign sel   = bus.memAddress[3:2];
   assign wr    = hit & bus.memWrite;
   assign rd    = hit & bus.memRead;
   assign tick  = baud_q == div_q;
   assign wmask = {{8{bus.byteMask[3]}}, {8{bus.byteMask[2]}}, {8{bus.byteMask[1]}}, {8{bus.byteMask[0]}}};
   assign tx_full     = tx_cnt_q == (TAW+1)'(TX_DEPTH);
   assign tx_empty    = tx_cnt_q == '0;
   assign tx_busy     = tx_st_q != S_IDLE;
   assign tx_push_req = wr && sel == 2'd0 && bus.byteMask[0];
   assign tx_pop      = tx_st_q == S_IDLE && ctrl_q[0] && !tx_empty;
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign rx_full     = rx_cnt_q == (RAW+1)'(RX_DEPTH);
   assign rx_empty    = rx_cnt_q == '0;
   assign rx_s        = rx_sync_q[1];
   assign rx_stop     = ctrl_q[1] && rx_st_q == S_STOP && tick && rx_tk_q == 4'd15;
   assign rx_push_req = rx_stop & rx_s;
   assign rx_pop      = rd && sel == 2'd0 && !rx_empty;
   assign rx_push     = rx_push_req && (!rx_full || rx_pop);
   assign flags_clr = (wr && sel == 2'd1 && bus.byteMask[0]) ? bus.memWriteData[7:5] : 3'b0;
   // flags_q = {TX_OVF, FRAME_ERR, RX_OVR}; a same-cycle event wins over its clear
   assign flags_d = (flags_q & ~flags_clr) | {tx_push_req & ~tx_push, rx_stop & ~rx_s, rx_push_req & ~rx_push};
   assign status  = {8'h0, 8'(rx_cnt_q), 8'(tx_cnt_q), flags_q, rx_full, !rx_empty, tx_empty, tx_full, tx_busy};
   assign ctrl_d  = (wr && sel == 2'd2) ? ((ctrl_q & ~wmask) | (bus.memWriteData & wmask)) & 32'hFFFF_000F : ctrl_q;
   assign rdata_d = !rd ? '0 :
                    sel == 2'd0 ? (rx_empty ? '0 : {23'b0, 1'b1, rx_mem_q[rx_rp_q]}) :
                    sel == 2'd1 ? status :
                    sel == 2'd2 ? ctrl_q : '0;
   assign bus.memReadData = rdata_q;
   assign uart_tx = tx_line_q;
   assign irq     = irq_q;
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem_q[tx_wp_q] <= bus.memWriteData[7:0];
      if (rx_push) rx_mem_q[rx_wp_q] <= rx_sh_q;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         ctrl_q   <= {CLK_DIV_DEFAULT, 12'h0, 4'b0011};
         rdata_q  <= '0;
         flags_q  <= '0;
         irq_q    <= 1'b0;
         baud_q   <= '0;
         div_q    <= CLK_DIV_DEFAULT;
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         ctrl_q   <= ctrl_d;
         rdata_q  <= rdata_d;
         flags_q  <= flags_d;
         irq_q    <= (ctrl_q[2] & !rx_empty) | (ctrl_q[3] & tx_empty & !tx_busy);
         baud_q   <= tick ? '0 : baud_q + 16'd1;
         // a new divisor is only picked up when the current tick period ends
         if (tick) div_q <= ctrl_q[31:16];
         if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
         if (tx_pop) tx_rp_q <= tx_rp_q + TAW'(1);
         tx_cnt_q <= tx_cnt_q + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
         if (rx_push) rx_wp_q <= rx_wp_q + RAW'(1);
         if (rx_pop) rx_rp_q <= rx_rp_q + RAW'(1);
         rx_cnt_q <= rx_cnt_q + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_st_q   <= S_IDLE;
         tx_line_q <= 1'b1;
         tx_tk_q   <= '0;
         tx_bit_q  <= '0;
         tx_sh_q   <= '0;
      end else begin
         case (tx_st_q)
            S_IDLE: if (tx_pop) begin
               tx_st_q   <= S_START;
               tx_line_q <= 1'b0;
               tx_tk_q   <= '0;
               tx_sh_q   <= tx_mem_q[tx_rp_q];
            end
            S_START: if (tick) begin
               tx_tk_q <= tx_tk_q + 4'd1;
               if (tx_tk_q == 4'd15) begin
                  tx_st_q   <= S_DATA;
                  tx_line_q <= tx_sh_q[0];
                  tx_bit_q  <= '0;
               end
            end
            S_DATA: if (tick) begin
               tx_tk_q <= tx_tk_q + 4'd1;
               if (tx_tk_q == 4'd15) begin
                  tx_sh_q   <= tx_sh_q >> 1;
                  tx_line_q <= tx_sh_q[1];
                  tx_bit_q  <= tx_bit_q + 3'd1;
                  if (tx_bit_q == 3'd7) begin
                     tx_st_q   <= S_STOP;
                     tx_line_q <= 1'b1;
                  end
               end
            end
            S_STOP: if (tick) begin
               tx_tk_q <= tx_tk_q + 4'd1;
               if (tx_tk_q == 4'd15) tx_st_q <= S_IDLE;
            end
            default: tx_st_q <= S_IDLE;
         endcase
      end
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_sync_q <= 2'b11;
         rx_prev_q <= 1'b1;
         rx_st_q   <= S_IDLE;
         rx_tk_q   <= '0;
         rx_bit_q  <= '0;
         rx_sh_q   <= '0;
      end else begin
         rx_sync_q <= {rx_sync_q[0], uart_rx};
         rx_prev_q <= rx_s;
         if (!ctrl_q[1]) rx_st_q <= S_IDLE;
         else case (rx_st_q)
            S_IDLE: if (rx_prev_q && !rx_s) begin
               rx_st_q <= S_START;
               rx_tk_q <= '0;
            end
            S_START: if (tick) begin
               rx_tk_q <= rx_tk_q + 4'd1;
               if (rx_tk_q == 4'd7) begin
                  rx_st_q  <= rx_s ? S_IDLE : S_DATA;
                  rx_tk_q  <= '0;
                  rx_bit_q <= '0;
               end
            end
            S_DATA: if (tick) begin
               rx_tk_q <= rx_tk_q + 4'd1;
               if (rx_tk_q == 4'd15) begin
                  rx_sh_q  <= {rx_s, rx_sh_q[7:1]};
                  rx_bit_q <= rx_bit_q + 3'd1;
                  if (rx_bit_q == 3'd7) rx_st_q <= S_STOP;
               end
            end
            S_STOP: if (tick) begin
               rx_tk_q <= rx_tk_q + 4'd1;
               if (rx_tk_q == 4'd15) rx_st_q <= S_IDLE;
            end
            default: rx_st_q <= S_IDLE;
         endcase
      end
   end
endmodule
